// File: rtl/core_hazard_ctrl_if.sv
// rtl/core_hazard_ctrl_if.sv - pipeline hazard control bundle between datapath and sequencer
interface core_hazard_ctrl_if;
  logic [4:0]  id_rs1_idx_i;
  logic [4:0]  id_rs2_idx_i;
  logic        id_rs1_use_i;
  logic        id_rs2_use_i;
  logic        ex_mem_read_i;
  logic [4:0]  ex_rsd_idx_i;
  logic        ex_muldiv_i;
  logic        ex_is_div_i;
  logic        ex_redirect_i;
  logic        mem_stall_i;
  logic        pc_wen_o;
  logic        if_id_wen_o;
  logic        if_id_flush_o;
  logic        id_ex_wen_o;
  logic        id_ex_flush_o;
  logic        ex_mem_flush_o;
  logic        md_start_o;
  logic        md_valid_o;
  logic [31:0] stall_cycles_o;

  modport master (
    output id_rs1_idx_i, id_rs2_idx_i, id_rs1_use_i, id_rs2_use_i,
           ex_mem_read_i, ex_rsd_idx_i, ex_muldiv_i, ex_is_div_i,
           ex_redirect_i, mem_stall_i,
    input  pc_wen_o, if_id_wen_o, if_id_flush_o, id_ex_wen_o, id_ex_flush_o,
           ex_mem_flush_o, md_start_o, md_valid_o, stall_cycles_o
  );

  modport slave (
    input  id_rs1_idx_i, id_rs2_idx_i, id_rs1_use_i, id_rs2_use_i,
           ex_mem_read_i, ex_rsd_idx_i, ex_muldiv_i, ex_is_div_i,
           ex_redirect_i, mem_stall_i,
    output pc_wen_o, if_id_wen_o, if_id_flush_o, id_ex_wen_o, id_ex_flush_o,
           ex_mem_flush_o, md_start_o, md_valid_o, stall_cycles_o
  );
endinterface

// File: rtl/core_hazard_ctrl.sv
// rtl/core_hazard_ctrl.sv - stall/flush sequencer for the 5-stage core and its MUL/DIV unit
module core_hazard_ctrl #(
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 34,
  parameter int CNT_W   = 7
) (
  input  logic               clk,
  input  logic               rst,
  core_hazard_ctrl_if.slave  hz
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [31:0]      stall_cnt;
  logic             load_use;

  logic pc_wen, if_id_wen, if_id_flush, id_ex_wen, id_ex_flush, ex_mem_flush;
  logic md_start, md_valid;

  // rd==x0 never creates a dependency: x0 is hard-wired zero
  always_comb begin
    load_use = hz.ex_mem_read_i && (hz.ex_rsd_idx_i != 5'd0) &&
               ((hz.id_rs1_use_i && (hz.id_rs1_idx_i == hz.ex_rsd_idx_i)) ||
                (hz.id_rs2_use_i && (hz.id_rs2_idx_i == hz.ex_rsd_idx_i)));
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    pc_wen       = 1'b1;
    if_id_wen    = 1'b1;
    id_ex_wen    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    md_start     = 1'b0;
    md_valid     = 1'b0;

    if (rst) begin
      pc_wen    = 1'b0;
      if_id_wen = 1'b0;
      id_ex_wen = 1'b0;
    end else if (hz.mem_stall_i) begin
      // Freeze everything; a finished result stays presented until the pipe moves
      pc_wen    = 1'b0;
      if_id_wen = 1'b0;
      id_ex_wen = 1'b0;
      md_valid  = (state == DONE);
    end else begin
      case (state)
        IDLE: begin
          if (hz.ex_redirect_i) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (hz.ex_muldiv_i) begin
            md_start     = 1'b1;
            pc_wen       = 1'b0;
            if_id_wen    = 1'b0;
            id_ex_wen    = 1'b0;
            ex_mem_flush = 1'b1;
            cnt_nxt      = hz.ex_is_div_i ? DIV_LOAD : MUL_LOAD;
            state_nxt    = BUSY;
          end else if (load_use) begin
            pc_wen      = 1'b0;
            if_id_wen   = 1'b0;
            id_ex_flush = 1'b1;
          end
        end
        BUSY: begin
          pc_wen       = 1'b0;
          if_id_wen    = 1'b0;
          id_ex_wen    = 1'b0;
          ex_mem_flush = 1'b1;
          if (cnt == CNT_ONE) begin
            state_nxt = DONE;
          end else begin
            cnt_nxt = cnt - CNT_ONE;
          end
        end
        DONE: begin
          md_valid  = 1'b1;
          state_nxt = IDLE;
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      stall_cnt <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (!pc_wen) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
    end
  end

  always_comb begin
    hz.pc_wen_o       = pc_wen;
    hz.if_id_wen_o    = if_id_wen;
    hz.if_id_flush_o  = if_id_flush;
    hz.id_ex_wen_o    = id_ex_wen;
    hz.id_ex_flush_o  = id_ex_flush;
    hz.ex_mem_flush_o = ex_mem_flush;
    hz.md_start_o     = md_start;
    hz.md_valid_o     = md_valid;
    hz.stall_cycles_o = stall_cnt;
  end

endmodule

// File: tb/tb_core_hazard_ctrl.sv
// tb/tb_core_hazard_ctrl.sv - directed self-checking bench for core_hazard_ctrl
module tb_core_hazard_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  core_hazard_ctrl_if hz();

  core_hazard_ctrl #(.MUL_LAT(3), .DIV_LAT(34), .CNT_W(7)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz.slave)
  );

  always #5 clk = ~clk;

  // {pc_wen, if_id_wen, if_id_flush, id_ex_wen, id_ex_flush, ex_mem_flush, md_start, md_valid}
  localparam logic [7:0] C_ZERO  = 8'b0000_0000;
  localparam logic [7:0] C_IDLE  = 8'b1101_0000;
  localparam logic [7:0] C_LU    = 8'b0001_1000;
  localparam logic [7:0] C_REDIR = 8'b1111_1000;
  localparam logic [7:0] C_ISSUE = 8'b0000_0110;
  localparam logic [7:0] C_BUSY  = 8'b0000_0100;
  localparam logic [7:0] C_DONE  = 8'b1101_0001;
  localparam logic [7:0] C_DSTL  = 8'b0000_0001;

  function automatic logic [7:0] ctl();
    return {hz.pc_wen_o, hz.if_id_wen_o, hz.if_id_flush_o, hz.id_ex_wen_o,
            hz.id_ex_flush_o, hz.ex_mem_flush_o, hz.md_start_o, hz.md_valid_o};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ctl(input string tag, input logic [7:0] exp);
    logic [7:0] obs;
    #1;
    obs = ctl();
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_cnt(input string tag, input logic [31:0] exp);
    logic [31:0] obs;
    #1;
    obs = hz.stall_cycles_o;
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clr();
    hz.id_rs1_idx_i  = 5'd0;
    hz.id_rs2_idx_i  = 5'd0;
    hz.id_rs1_use_i  = 1'b0;
    hz.id_rs2_use_i  = 1'b0;
    hz.ex_mem_read_i = 1'b0;
    hz.ex_rsd_idx_i  = 5'd0;
    hz.ex_muldiv_i   = 1'b0;
    hz.ex_is_div_i   = 1'b0;
    hz.ex_redirect_i = 1'b0;
    hz.mem_stall_i   = 1'b0;
  endtask

  initial begin
    clr();
    rst = 1'b1;
    #1;
    chk_ctl("reset_ctl", C_ZERO);
    cyc();
    cyc();
    chk_cnt("reset_cnt", 32'd0);
    rst = 1'b0;
    chk_ctl("idle_default", C_IDLE);
    cyc();

    // load-use through rs2, then same with rd=x0
    hz.ex_mem_read_i = 1'b1; hz.ex_rsd_idx_i = 5'd5;
    hz.id_rs2_idx_i = 5'd5;  hz.id_rs2_use_i = 1'b1;
    chk_ctl("lu_rs2", C_LU);
    cyc();
    chk_cnt("lu_rs2_cnt", 32'd1);
    hz.ex_rsd_idx_i = 5'd0;
    hz.id_rs2_idx_i = 5'd0;
    chk_ctl("lu_x0", C_IDLE);
    cyc();

    // load-use through rs1, then the same indices with rs1 unused
    clr();
    hz.ex_mem_read_i = 1'b1; hz.ex_rsd_idx_i = 5'd7;
    hz.id_rs1_idx_i = 5'd7;  hz.id_rs1_use_i = 1'b1;
    chk_ctl("lu_rs1", C_LU);
    cyc();
    hz.id_rs1_use_i = 1'b0;
    chk_ctl("lu_rs1_unused", C_IDLE);
    chk_cnt("lu_rs1_cnt", 32'd2);

    // redirect wins over a live load-use
    hz.id_rs1_use_i  = 1'b1;
    hz.ex_redirect_i = 1'b1;
    chk_ctl("redirect_over_lu", C_REDIR);
    cyc();
    clr();
    chk_cnt("redirect_cnt", 32'd2);

    // MUL: ex_muldiv_i stays high while ID/EX is frozen
    hz.ex_muldiv_i = 1'b1;
    chk_ctl("mul_issue", C_ISSUE);
    cyc();
    chk_ctl("mul_busy1", C_BUSY);
    cyc();
    hz.ex_mem_read_i = 1'b1; hz.ex_rsd_idx_i = 5'd3;
    hz.id_rs1_idx_i = 5'd3;  hz.id_rs1_use_i = 1'b1;
    chk_ctl("mul_busy2_ignore_lu", C_BUSY);
    cyc();
    clr();
    hz.ex_muldiv_i = 1'b1;
    chk_ctl("mul_done", C_DONE);
    cyc();
    hz.ex_muldiv_i = 1'b0;
    chk_ctl("mul_idle", C_IDLE);
    chk_cnt("mul_cnt", 32'd5);

    // DIV with a 5-cycle memory stall inside BUSY
    hz.ex_muldiv_i = 1'b1; hz.ex_is_div_i = 1'b1;
    chk_ctl("div_issue", C_ISSUE);
    cyc();
    for (int k = 1; k <= 38; k++) begin
      hz.mem_stall_i = (k >= 10 && k <= 14);
      chk_ctl($sformatf("div_k%0d", k), hz.mem_stall_i ? C_ZERO : C_BUSY);
      cyc();
    end
    hz.mem_stall_i = 1'b0;
    chk_ctl("div_done_t39", C_DONE);
    cyc();
    clr();
    chk_ctl("div_idle", C_IDLE);
    chk_cnt("div_cnt", 32'd44);

    // MUL whose DONE cycle is held by a memory stall
    hz.ex_muldiv_i = 1'b1;
    chk_ctl("mul2_issue", C_ISSUE);
    cyc();
    chk_ctl("mul2_busy1", C_BUSY);
    cyc();
    chk_ctl("mul2_busy2", C_BUSY);
    cyc();
    hz.mem_stall_i = 1'b1;
    chk_ctl("mul2_done_stall1", C_DSTL);
    cyc();
    chk_ctl("mul2_done_stall2", C_DSTL);
    cyc();
    hz.mem_stall_i = 1'b0;
    chk_ctl("mul2_done_release", C_DONE);
    cyc();
    hz.ex_muldiv_i = 1'b0;
    chk_ctl("mul2_idle", C_IDLE);
    chk_cnt("mul2_cnt", 32'd49);

    // memory stall in IDLE blocks a MUL issue
    hz.ex_muldiv_i = 1'b1;
    hz.mem_stall_i = 1'b1;
    chk_ctl("idle_memstall_no_issue", C_ZERO);
    cyc();
    clr();
    chk_ctl("idle_after_memstall", C_IDLE);
    chk_cnt("memstall_cnt", 32'd50);

    // DIV aborted by reset at T+10
    hz.ex_muldiv_i = 1'b1; hz.ex_is_div_i = 1'b1;
    chk_ctl("div2_issue", C_ISSUE);
    cyc();
    for (int k = 1; k < 10; k++) begin
      cyc();
    end
    rst = 1'b1;
    chk_ctl("div2_reset_ctl", C_ZERO);
    cyc();
    rst = 1'b0;
    clr();
    chk_ctl("div2_post_reset", C_IDLE);
    chk_cnt("div2_post_reset_cnt", 32'd0);
    for (int k = 0; k < 30; k++) begin
      chk_ctl($sformatf("div2_no_valid_%0d", k), C_IDLE);
      cyc();
    end
    chk_cnt("div2_final_cnt", 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/core_hazard_ctrl.md
Name: core_hazard_ctrl

Overview:
- Pipeline sequencer for the RV64IM 5-stage core.
- Drives write-enable and bubble-insert (flush) controls of the PC, IF/ID, ID/EX and EX/MEM stage registers.
- Handles three cases: load-use stalls, taken-branch/jump redirect flushes and external memory stalls.
- Sequences the multi-cycle MUL/DIV unit in EX with an FSM and a latency counter.

Parameters:
- MUL_LAT, 3, cycles from MUL issue to result valid; must be at least 2.
- DIV_LAT, 34, cycles from DIV/REM issue to result valid; must be at least 2.
- CNT_W, 7, latency counter width; must satisfy 2^CNT_W > max(MUL_LAT, DIV_LAT).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- id_rs1_idx_i  in  5  rs1 index of the instruction in ID
- id_rs2_idx_i  in  5  rs2 index of the instruction in ID
- id_rs1_use_i  in  1  ID instruction reads rs1
- id_rs2_use_i  in  1  ID instruction reads rs2
- ex_mem_read_i  in  1  ID/EX holds a load
- ex_rsd_idx_i  in  5  destination index held in ID/EX
- ex_muldiv_i  in  1  ID/EX holds an M-extension instruction
- ex_is_div_i  in  1  that M-extension instruction is DIV/REM class (selects DIV_LAT)
- ex_redirect_i  in  1  taken branch or jump resolved in EX
- mem_stall_i  in  1  data memory busy; freeze the whole pipe
- pc_wen_o  out  1  PC write enable
- if_id_wen_o  out  1  IF/ID write enable
- if_id_flush_o  out  1  IF/ID loads a bubble
- id_ex_wen_o  out  1  ID/EX write enable
- id_ex_flush_o  out  1  ID/EX loads a bubble (control fields cleared)
- ex_mem_flush_o  out  1  EX/MEM loads a bubble
- md_start_o  out  1  one-cycle MUL/DIV start pulse
- md_valid_o  out  1  MUL/DIV result valid; EX/MEM captures it this cycle
- stall_cycles_o  out  32  count of cycles with pc_wen_o equal to 0

Behaviour:
- State: FSM {IDLE, BUSY, DONE}, down-counter cnt[CNT_W-1:0], 32-bit stall counter.
- Reset (rst high): state goes to IDLE, cnt to 0, stall_cycles_o to 0.
  - While rst is high, all wen, flush, md_start_o and md_valid_o outputs are 0.
- mem_stall_i high (highest priority after reset):
  - All wen outputs 0, all flush outputs 0, md_start_o 0.
  - FSM and cnt hold their values.
  - md_valid_o stays high if the state is DONE.
- Default, IDLE with no event: all wen 1, all flush 0.
- Redirect, IDLE and ex_redirect_i: if_id_flush_o=1, id_ex_flush_o=1, pc_wen_o=1.
  - Redirect overrides load-use.
  - ex_redirect_i and ex_muldiv_i are never both high.
- Load-use, IDLE, no redirect, no muldiv. Condition: ex_mem_read_i, ex_rsd_idx_i != 0, and (rs1 match with rs1_use, or rs2 match with rs2_use).
  - Response: pc_wen_o=0, if_id_wen_o=0, id_ex_flush_o=1.
- MUL/DIV issue, IDLE and ex_muldiv_i, cycle T:
  - md_start_o=1.
  - pc_wen_o, if_id_wen_o and id_ex_wen_o all 0.
  - ex_mem_flush_o=1.
  - cnt loads LAT-1, where LAT is DIV_LAT if ex_is_div_i else MUL_LAT. State goes to BUSY.
- BUSY:
  - Same stall outputs as issue, md_start_o=0.
  - If cnt==1, go to DONE; else decrement cnt.
  - ID-stage load-use and redirect inputs are ignored.
- DONE (cycle T+LAT):
  - md_valid_o=1; all wen 1; all flush 0.
  - Unconditionally return to IDLE.
  - The next EX instruction is evaluated fresh in IDLE, so the same instruction never re-triggers.
- Latency: EX is occupied for LAT+1 cycles; md_valid_o asserts exactly LAT cycles after md_start_o.
- Reset mid-operation: abort the sequence, return to IDLE; md_valid_o is never asserted for the aborted instruction.
- Stall counter: increments by 1 each non-reset cycle in which pc_wen_o==0, including mem_stall cycles; wraps from 2^32-1 to 0.
- Control outputs are combinational from state and inputs. No output depends on the same cycle's md_valid_o.

Test Plan:
- Load-use: ex_mem_read_i=1, ex_rsd_idx_i=5, id_rs2_idx_i=5, id_rs2_use_i=1 for one cycle -> pc_wen_o=0, if_id_wen_o=0, id_ex_flush_o=1; repeat with ex_rsd_idx_i=0 -> no stall.
- MUL with MUL_LAT=3: ex_muldiv_i=1, ex_is_div_i=0 at T -> md_start_o=1 only at T; stalls at T..T+2; md_valid_o=1 at T+3; IDLE at T+4; stall_cycles_o=3.
- DIV with DIV_LAT=34: md_valid_o exactly 34 cycles after md_start_o. mem_stall_i high for 5 cycles during BUSY -> md_valid_o delayed to 39 cycles; md_start_o never re-pulses.
- Redirect beats load-use: ex_redirect_i=1 together with a matching load-use condition -> pc_wen_o=1, if_id_flush_o=1, id_ex_flush_o=1, if_id_wen_o=1.
- Reset mid-DIV: rst high at T+10 for 1 cycle -> all outputs 0 during reset; IDLE afterwards with all wen 1; md_valid_o never asserts; stall_cycles_o=0.
- mem_stall_i high while state is DONE -> md_valid_o stays 1 and all wen stay 0 until mem_stall_i falls, then one cycle with all wen 1, then IDLE.
